// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg -- shared definitions for the display scheduler.
//   * FSM state encoding (IDLE / CONV / DONE)
//   * BCD geometry (4-bit digits, 5 digits of result, 16-bit binary input)
//   * double-dabble iteration count (16) and its last-iteration index
//   * saturation constant (9999 in packed BCD) used when DISP_SAT_EN is defined
//   * default scan divider (50 MHz / 50000 = 1 kHz)
// -----------------------------------------------------------------------------
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 5;
  localparam int BCD_W       = BCD_DIGITS * BCD_DIGIT_W;  // 20-bit result field
  localparam int BIN_W       = 16;                        // binary input width
  localparam int DISP_W      = 16;                        // four displayed digits
  localparam int WORK_W      = BCD_W + BIN_W;             // shift register width

  localparam int ITER_COUNT = 16;
  localparam int ITER_W     = $clog2(ITER_COUNT);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_COUNT - 1);

  localparam logic [DISP_W-1:0] SAT_BCD = 16'h9999;

  localparam int CLK_DIV_DEFAULT = 50000;

endpackage

// File: rtl/bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step -- one combinational double-dabble iteration.
// Every BCD digit of the upper 20 bits that is >= 5 gets 3 added, then the
// whole {bcd, binary} vector shifts left by one bit.
// Ports:
//   data_i  [35:0]  {bcd[19:0], bin[15:0]} before the iteration
//   data_o  [35:0]  {bcd[19:0], bin[15:0]} after the iteration
// -----------------------------------------------------------------------------
module bcd_dabble_step
  import disp_pkg::*;
(
  input  logic [WORK_W-1:0] data_i,
  output logic [WORK_W-1:0] data_o
);

  logic [WORK_W-1:0] adj;

  assign adj[BIN_W-1:0] = data_i[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      logic [BCD_DIGIT_W-1:0] digit;
      assign digit = data_i[BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W];
      assign adj[BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
        (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  endgenerate

  assign data_o = {adj[WORK_W-2:0], 1'b0};

endmodule

// File: rtl/disp_scheduler.sv
// -----------------------------------------------------------------------------
// disp_scheduler -- arbitrates two display requesters (CPU, debug monitor),
// converts the granted 16-bit binary value to packed BCD by double dabble
// (one iteration per clock) and drives a 7-segment scan driver.
//
// Configuration macro: DISP_SAT_EN
//   defined   -> values above 9999 display as 9999
//   undefined -> the lowest four BCD digits are displayed (value mod 10000)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   req_cpu  in   CPU request (level, held until gnt_cpu)
//   val_cpu  in   CPU value, captured on the grant edge
//   req_dbg  in   debug request (level, held until gnt_dbg)
//   val_dbg  in   debug value, captured on the grant edge
//   blank    in   force the display dark
//   gnt_cpu  out  one-cycle grant to CPU
//   gnt_dbg  out  one-cycle grant to debug
//   busy     out  conversion in progress
//   din      out  four packed BCD digits, [15:12] most significant
//   light    out  display enable
//   tick_1k  out  one-cycle scan strobe every CLK_DIV clocks
// -----------------------------------------------------------------------------
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_cpu,
  input  logic [BIN_W-1:0]  val_cpu,
  input  logic              req_dbg,
  input  logic [BIN_W-1:0]  val_dbg,
  input  logic              blank,
  output logic              gnt_cpu,
  output logic              gnt_dbg,
  output logic              busy,
  output logic [DISP_W-1:0] din,
  output logic              light,
  output logic              tick_1k
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_e              state_q, state_d;
  logic                prio_dbg_q, prio_dbg_d;   // 1: debug wins the next tie
  logic                gnt_cpu_q, gnt_cpu_d;
  logic                gnt_dbg_q, gnt_dbg_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [DISP_W-1:0]   din_q, din_d;
  logic                light_q, light_d;
  logic                done_seen_q, done_seen_d; // a conversion has completed
  logic [15:0]         div_q;
  logic                tick_q;

  logic [WORK_W-1:0]   step_out;
  logic [DISP_W-1:0]   conv_result;
  logic                grant_dbg;

  bcd_dabble_step u_step (
    .data_i (work_q),
    .data_o (step_out)
  );

  // Decide what the finished conversion shows. The fifth BCD digit being
  // non-zero is exactly "value > 9999".
`ifdef DISP_SAT_EN
  assign conv_result = (work_q[BIN_W + DISP_W +: BCD_DIGIT_W] != '0)
                     ? SAT_BCD : work_q[BIN_W +: DISP_W];
`else
  assign conv_result = work_q[BIN_W +: DISP_W];
`endif

  always_comb begin
    state_d     = state_q;
    prio_dbg_d  = prio_dbg_q;
    gnt_cpu_d   = 1'b0;
    gnt_dbg_d   = 1'b0;
    work_d      = work_q;
    iter_d      = iter_q;
    din_d       = din_q;
    done_seen_d = done_seen_q;
    grant_dbg   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_cpu || req_dbg) begin
          // Debug wins when it is the only requester or holds the tie token.
          grant_dbg  = req_dbg && (!req_cpu || prio_dbg_q);
          gnt_dbg_d  = grant_dbg;
          gnt_cpu_d  = !grant_dbg;
          prio_dbg_d = !grant_dbg;
          work_d     = {{BCD_W{1'b0}}, (grant_dbg ? val_dbg : val_cpu)};
          iter_d     = '0;
          state_d    = CONV;
        end
      end
      CONV: begin
        work_d = step_out;
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        din_d       = conv_result;
        done_seen_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Light follows blank with one register of latency, but stays dark until
    // something has been displayed; a DONE this cycle counts as displayed.
    light_d = !blank && (done_seen_q || (state_q == DONE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      prio_dbg_q  <= 1'b0;
      gnt_cpu_q   <= 1'b0;
      gnt_dbg_q   <= 1'b0;
      work_q      <= '0;
      iter_q      <= '0;
      din_q       <= '0;
      light_q     <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_dbg_q  <= prio_dbg_d;
      gnt_cpu_q   <= gnt_cpu_d;
      gnt_dbg_q   <= gnt_dbg_d;
      work_q      <= work_d;
      iter_q      <= iter_d;
      din_q       <= din_d;
      light_q     <= light_d;
      done_seen_q <= done_seen_d;
    end
  end

  // Free-running scan divider, independent of the conversion FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DIV_LAST);
      if (div_q == DIV_LAST) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + 16'd1;
      end
    end
  end

  assign gnt_cpu = gnt_cpu_q;
  assign gnt_dbg = gnt_dbg_q;
  assign busy    = (state_q != IDLE);
  assign din     = din_q;
  assign light   = light_q;
  assign tick_1k = tick_q;

endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter: CLK_DIV, default 50000, system clocks per scan tick (1 kHz at 50 MHz); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_cpu  input  1  CPU display request; level, held until gnt_cpu.
REQ-005 val_cpu  input  16  CPU binary value; sampled on gnt_cpu cycle.
REQ-006 req_dbg  input  1  debug (PC monitor) display request; level, held until gnt_dbg.
REQ-007 val_dbg  input  16  debug binary value; sampled on gnt_dbg cycle.
REQ-008 blank  input  1  force display dark while high.
REQ-009 gnt_cpu  output  1  one-cycle grant pulse to CPU.
REQ-010 gnt_dbg  output  1  one-cycle grant pulse to debug.
REQ-011 busy  output  1  conversion in progress.
REQ-012 din  output  16  four packed BCD digits, [15:12] most significant, for the 7-seg driver.
REQ-013 light  output  1  display enable for the 7-seg driver.
REQ-014 tick_1k  output  1  one-cycle scan strobe for the 7-seg driver.

Function
REQ-015 FSM states SHALL be IDLE, CONV, DONE; only IDLE accepts requests.
REQ-016 In IDLE with any request at edge k: grant exactly one requester (gnt high the cycle after edge k), capture its value, clear iteration count, go CONV, assert busy.
REQ-017 Simultaneous requests SHALL be resolved round-robin; after reset CPU has priority; the last-granted requester loses the next tie.
REQ-018 CONV SHALL perform one double-dabble iteration per cycle (add 3 to each BCD digit >=5, then shift left by one) for exactly 16 iterations into a 20-bit (5-digit) result; on the 16th iteration go DONE.
REQ-019 In DONE: load din, set light=~blank, drop busy, return to IDLE; din valid after edge k+17.
REQ-020 Requests arriving in CONV/DONE SHALL wait; no grant while busy.
REQ-021 din SHALL hold its value between conversions and is unaffected by blank.
REQ-022 light SHALL be 0 while blank is high (registered, 1-cycle latency); on blank falling, light returns to 1 only if at least one conversion has completed since reset.
REQ-023 blank and DONE in same cycle: din updates, light=0.
REQ-024 tick_1k: free-running counter 0..CLK_DIV-1, pulse high one cycle when counter = CLK_DIV-1, then wrap to 0; independent of FSM.

Reset
REQ-025 While reset low: state IDLE, din=16'h0000, light=0, busy=0, gnt_cpu=gnt_dbg=0, tick_1k=0, divider=0, round-robin pointer=CPU.
REQ-026 Reset mid-conversion SHALL abandon it; din keeps reset value; a still-held request is re-granted after release.

Configuration
REQ-027 Macro DISP_SAT_EN: defined -> captured values >9999 SHALL display 9999; undefined -> din shows the lowest four BCD digits (value mod 10000), fifth digit discarded.
REQ-028 Saturation compare SHALL occur at DONE; conversion latency identical in both builds.

Structure
REQ-029 Shared package disp_pkg SHALL hold the FSM state enum, BCD digit width (4), iteration count (16), saturation constant 9999 (16'h9999 BCD), and CLK_DIV default.
REQ-030 One combinational sub-module bcd_dabble_step SHALL implement a single add-3-and-shift iteration on the 20-bit BCD + 16-bit binary vector.

Verification
REQ-031 CPU req with val_cpu=1234 from IDLE -> gnt_cpu 1 cycle, busy 17 cycles, din=16'h1234, light=1.
REQ-032 req_cpu and req_dbg together (val 5, 42), both held -> first din=16'h0005, then din=16'h0042; next tie grants CPU.
REQ-033 val_dbg=65535 -> DISP_SAT_EN: din=16'h9999; without: din=16'h5535.
REQ-034 CLK_DIV=4 -> tick_1k high every 4th cycle, first after 4 cycles from reset release.
REQ-035 blank raised during conversion of 0 -> din=16'h0000, light=0; blank lowered -> light=1 one cycle later.
REQ-036 reset asserted at iteration 8 of val_cpu=9876 with req_cpu held -> outputs at reset values; after release, re-grant and din=16'h9876.
